// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the program counter, the instruction-memory
// request handshake and the IF/ID pipeline buffer feeding decode.
//   state   | meaning
//   RUN     | fetching; stalls, flushes and branch redirects honoured
//   HALTED  | halt retired in ID; no requests, IF/ID held as bubble until reset
module fetch_stage #(
    parameter int unsigned AW       = 16,
    parameter int unsigned IW       = 16,
    parameter int unsigned PC_INC   = 2,
    parameter int unsigned RESET_PC = 0,
    parameter int unsigned NOP      = 0
) (
    input  logic          clock,
    input  logic          reset,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    input  logic          imem_ready,
    input  logic [IW-1:0] imem_rdata,
    input  logic          pc_stop,
    input  logic          if_id_buffer_flush,
    input  logic          branch_taken,
    input  logic [AW-1:0] branch_target,
    input  logic          halt,
    output logic [IW-1:0] id_instruction,
    output logic [AW-1:0] id_pc_next_address,
    output logic          id_valid,
    output logic          halted,
    output logic [31:0]   fetch_count
);

    typedef enum logic {RUN = 1'b0, HALTED = 1'b1} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [IW-1:0] id_instr_q, id_instr_d;
    logic [AW-1:0] id_pcn_q, id_pcn_d;
    logic          id_valid_q, id_valid_d;
    logic [31:0]   fetch_count_q, fetch_count_d;

    logic          is_halted;
    logic          accept;
    logic [AW-1:0] pc_inc;

    assign is_halted = (state_q == HALTED);
    assign imem_req  = !is_halted && !pc_stop && !branch_taken;
    assign imem_addr = pc_q;
    assign accept    = imem_req && imem_ready && !if_id_buffer_flush && !halt;
    assign pc_inc    = pc_q + AW'(PC_INC);

    assign id_instruction     = id_instr_q;
    assign id_pc_next_address = id_pcn_q;
    assign id_valid           = id_valid_q;
    assign halted             = is_halted;
    assign fetch_count        = fetch_count_q;

    always_comb begin
        // A taken branch is older than the halt sitting in ID, so it cancels it.
        state_d = state_q;
        if (!is_halted && halt && !branch_taken) begin
            state_d = HALTED;
        end

        // accept already excludes halt and pc_stop, so those fall through as hold.
        pc_d = pc_q;
        if (!is_halted) begin
            if (branch_taken) begin
                pc_d = branch_target & ~AW'(1);
            end else if (accept) begin
                pc_d = pc_inc;
            end
        end

        id_instr_d = IW'(NOP);
        id_pcn_d   = '0;
        id_valid_d = 1'b0;
        if (if_id_buffer_flush || branch_taken || is_halted || halt) begin
            id_instr_d = IW'(NOP);
            id_pcn_d   = '0;
            id_valid_d = 1'b0;
        end else if (pc_stop) begin
            id_instr_d = id_instr_q;
            id_pcn_d   = id_pcn_q;
            id_valid_d = id_valid_q;
        end else if (accept) begin
            id_instr_d = imem_rdata;
            id_pcn_d   = pc_inc;
            id_valid_d = 1'b1;
        end

        fetch_count_d = fetch_count_q;
        if (accept && (fetch_count_q != 32'hFFFF_FFFF)) begin
            fetch_count_d = fetch_count_q + 32'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= RUN;
            pc_q          <= AW'(RESET_PC);
            id_instr_q    <= IW'(NOP);
            id_pcn_q      <= '0;
            id_valid_q    <= 1'b0;
            fetch_count_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            id_instr_q    <= id_instr_d;
            id_pcn_q      <= id_pcn_d;
            id_valid_q    <= id_valid_d;
            fetch_count_q <= fetch_count_d;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed sequences plus randomized traffic, checked
// against a reference model with a scoreboard for the IF/ID output.
module tb_fetch_stage;
    localparam int AW = 16;
    localparam int IW = 16;

    logic          clock = 1'b0;
    logic          reset;
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_ready;
    logic [IW-1:0] imem_rdata;
    logic          pc_stop;
    logic          if_id_buffer_flush;
    logic          branch_taken;
    logic [AW-1:0] branch_target;
    logic          halt;
    logic [IW-1:0] id_instruction;
    logic [AW-1:0] id_pc_next_address;
    logic          id_valid;
    logic          halted;
    logic [31:0]   fetch_count;

    fetch_stage #(.AW(AW), .IW(IW), .PC_INC(2), .RESET_PC(0), .NOP(0)) dut (
        .clock(clock), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .pc_stop(pc_stop), .if_id_buffer_flush(if_id_buffer_flush),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .halt(halt),
        .id_instruction(id_instruction), .id_pc_next_address(id_pc_next_address),
        .id_valid(id_valid), .halted(halted), .fetch_count(fetch_count)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int            c;
        logic [IW-1:0] ins;
        logic [AW-1:0] pcn;
    } exp_t;
    exp_t sbq[$];
    exp_t mon_e;

    // reference model state
    logic [AW-1:0] m_pc;
    logic          m_halt;
    logic [31:0]   m_cnt;
    logic          m_v;
    logic [IW-1:0] m_ins;
    logic [AW-1:0] m_pcn;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = '0; m_halt = 1'b0; m_cnt = '0;
        m_v = 1'b0; m_ins = '0; m_pcn = '0;
        sbq.delete();
    endtask

    // One clock of stimulus: drive, check the PC-side outputs, advance the model,
    // and queue what IF/ID must show after the coming edge.
    task automatic step(input logic stop, input logic fl, input logic br,
                        input logic [AW-1:0] tgt, input logic hl,
                        input logic rdy, input logic [IW-1:0] rd);
        logic req, acc;
        @(negedge clock);
        pc_stop = stop; if_id_buffer_flush = fl; branch_taken = br;
        branch_target = tgt; halt = hl; imem_ready = rdy; imem_rdata = rd;
        #1;
        req = !m_halt && !stop && !br;
        acc = req && rdy && !fl && !hl;
        check("imem_addr", 64'(imem_addr), 64'(m_pc));
        check("imem_req", 64'(imem_req), 64'(req));
        check("halted", 64'(halted), 64'(m_halt));
        check("fetch_count", 64'(fetch_count), 64'(m_cnt));

        if (fl || br || m_halt || hl) begin
            m_v = 1'b0; m_ins = '0; m_pcn = '0;
        end else if (stop) begin
            m_v = m_v;
        end else if (acc) begin
            m_v = 1'b1; m_ins = rd; m_pcn = m_pc + 16'd2;
        end else begin
            m_v = 1'b0; m_ins = '0; m_pcn = '0;
        end
        if (m_v) sbq.push_back('{cyc + 1, m_ins, m_pcn});

        if (!m_halt) begin
            if (br) m_pc = {tgt[AW-1:1], 1'b0};
            else if (acc) m_pc = m_pc + 16'd2;
        end
        if (acc && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
        if (!m_halt && hl && !br) m_halt = 1'b1;
    endtask

    task automatic check_reset_values();
        check("rst_imem_addr", 64'(imem_addr), 64'h0);
        check("rst_id_instruction", 64'(id_instruction), 64'h0);
        check("rst_id_pc_next", 64'(id_pc_next_address), 64'h0);
        check("rst_id_valid", 64'(id_valid), 64'h0);
        check("rst_halted", 64'(halted), 64'h0);
        check("rst_fetch_count", 64'(fetch_count), 64'h0);
    endtask

    // Reset pulse placed mid-cycle while stalled; checked before the next edge.
    task automatic pulse_reset();
        @(negedge clock);
        pc_stop = 1'b1; if_id_buffer_flush = 1'b0; branch_taken = 1'b0;
        halt = 1'b0; imem_ready = 1'b1;
        #2 reset = 1'b1;
        #1 check_reset_values();
        model_reset();
        #1 reset = 1'b0;
    endtask

    // Monitor: pops the scoreboard whenever IF/ID is due to hold a real instruction.
    always @(negedge clock) begin
        if (!reset) begin
            if (sbq.size() > 0 && sbq[0].c == cyc) begin
                mon_e = sbq.pop_front();
                check("id_valid", 64'(id_valid), 64'h1);
                check("id_instruction", 64'(id_instruction), 64'(mon_e.ins));
                check("id_pc_next_address", 64'(id_pc_next_address), 64'(mon_e.pcn));
            end else begin
                check("id_valid_bubble", 64'(id_valid), 64'h0);
            end
        end
    end

    initial begin
        reset = 1'b1;
        pc_stop = 1'b1; if_id_buffer_flush = 1'b0; branch_taken = 1'b0;
        branch_target = '0; halt = 1'b0; imem_ready = 1'b0; imem_rdata = '0;
        model_reset();
        #3 check_reset_values();
        #1 reset = 1'b0;

        // sequential fetch, then memory wait at PC 4
        step(0, 0, 0, 16'h0, 0, 1, 16'h1234);
        step(0, 0, 0, 16'h0, 0, 1, 16'h5678);
        step(0, 0, 0, 16'h0, 0, 0, 16'hDEAD);
        step(0, 0, 0, 16'h0, 0, 0, 16'hDEAD);
        step(0, 0, 0, 16'h0, 0, 1, 16'h9ABC);
        // stall, then stall together with branch, then released
        step(1, 0, 0, 16'h0, 0, 1, 16'h1111);
        step(1, 0, 0, 16'h0, 0, 1, 16'h2222);
        step(1, 0, 0, 16'h0, 0, 1, 16'h3333);
        step(1, 0, 1, 16'h0041, 0, 1, 16'h4444);
        step(0, 0, 0, 16'h0, 0, 1, 16'h5555);
        // flush drops the word and refetches the same address
        step(0, 1, 0, 16'h0, 0, 1, 16'hBEEF);
        step(0, 0, 0, 16'h0, 0, 1, 16'hCAFE);
        // halt cancelled by simultaneous branch, then real halt
        step(0, 0, 1, 16'h0010, 1, 1, 16'h0);
        step(0, 0, 0, 16'h0, 0, 1, 16'h7777);
        step(0, 0, 0, 16'h0, 1, 1, 16'h8888);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 16'h0, 0, 1, 16'(i));
        pulse_reset();
        // wrap at the top of the address space
        step(0, 0, 1, 16'hFFFF, 0, 1, 16'h0);
        step(0, 0, 0, 16'h0, 0, 1, 16'hA5A5);
        step(0, 0, 0, 16'h0, 0, 1, 16'h5A5A);
        step(1, 0, 0, 16'h0, 0, 1, 16'h0);
        pulse_reset();

        // randomized traffic, a reset starting each block
        for (int blk = 0; blk < 20; blk++) begin
            for (int i = 0; i < 150; i++) begin
                step($urandom_range(0, 5) == 0,
                     $urandom_range(0, 9) == 0,
                     $urandom_range(0, 9) == 0,
                     ($urandom_range(0, 3) == 0) ? 16'(16'hFFFF - $urandom_range(0, 3)) : 16'($urandom),
                     $urandom_range(0, 99) == 0,
                     $urandom_range(0, 3) != 0,
                     16'($urandom));
            end
            pulse_reset();
        end

        step(0, 0, 0, 16'h0, 0, 1, 16'h0);
        @(negedge clock);
        #2 check("scoreboard_drained", 64'(sbq.size()), 64'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
